// File: rtl/stage1_if_if.sv
// Fetch-stage port bundle: SRAM-like instruction bus and the fs_to_ds handshake.
// master = fetch stage, slave = memory / decode side.
interface stage1_if_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        ds_allow_in;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size,
        output inst_sram_wstrb, inst_sram_wdata, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  ds_allow_in,
        output fs_to_ds_valid, fs_to_ds_bus
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size,
        input  inst_sram_wstrb, inst_sram_wdata, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output ds_allow_in,
        input  fs_to_ds_valid, fs_to_ds_bus
    );
endinterface

// File: rtl/stage1_if.sv
// Instruction-fetch stage: issues fetches, buffers {inst, pc}, handles redirects.
// IF_PREFETCH_EN: two outstanding requests / two buffer entries (else one).
module stage1_if (
    input  logic        clk,
    input  logic        resetn,
    input  logic [33:0] br_bus,
    stage1_if_if.master b
);

`ifdef IF_PREFETCH_EN
    localparam int N  = 2;
    localparam int CW = 2;
`else
    localparam int N  = 1;
    localparam int CW = 1;
`endif
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic          started_q, started_d;
    logic          tgt_q, tgt_d;
    logic          stale_q, stale_d;
    logic          br_pending_q, br_pending_d;
    logic [31:0]   br_target_q, br_target_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [63:0]   buf_q [N];
    logic [63:0]   buf_d [N];
    logic [31:0]   pcq_q [N];
    logic [31:0]   pcq_d [N];

    logic          cancel, acc, dok, pop, keep;
    logic [CW:0]   occ_d;
    int            bidx, pidx;
    logic          unused_br_taken;

    assign unused_br_taken = br_bus[32];
    assign cancel = br_bus[33];
    assign acc    = req_q & b.inst_sram_addr_ok;
    assign dok    = b.inst_sram_data_ok;
    assign pop    = (buf_cnt_q != '0) & b.ds_allow_in;
    assign keep   = dok & (discard_q == '0) & ~cancel;
    assign bidx   = int'(buf_cnt_q) - int'(pop);
    assign pidx   = int'(out_cnt_q) - int'(dok);

    always_comb begin
        out_cnt_d    = out_cnt_q + CW'(acc) - CW'(dok);
        buf_cnt_d    = cancel ? '0 : buf_cnt_q + CW'(keep) - CW'(pop);
        occ_d        = {1'b0, out_cnt_d} + {1'b0, buf_cnt_d};
        br_target_d  = cancel ? br_bus[31:0] : br_target_q;
        br_pending_d = br_pending_q;
        stale_d      = stale_q;
        discard_d    = discard_q - CW'(dok && discard_q != '0)
                     + CW'(acc && stale_q);
        if (acc) stale_d = 1'b0;
        if (acc && tgt_q && !stale_q) br_pending_d = 1'b0;
        // Everything still owed after this edge belongs to the old path.
        if (cancel) begin
            br_pending_d = 1'b1;
            stale_d      = req_q & ~acc;
            discard_d    = out_cnt_d;
        end
    end

    always_comb begin
        req_d     = 1'b0;
        addr_d    = addr_q;
        tgt_d     = 1'b0;
        started_d = started_q;
        if (req_q && !acc) begin
            req_d = 1'b1;
            tgt_d = tgt_q;
        end else if (occ_d < (CW+1)'(N)) begin
            req_d     = 1'b1;
            started_d = 1'b1;
            tgt_d     = started_q & br_pending_d;
            if (!started_q)
                addr_d = RESET_PC;
            else if (br_pending_d)
                addr_d = br_target_d;
            else
                addr_d = addr_q + 32'd4;
        end
    end

    always_comb begin
        buf_d = buf_q;
        pcq_d = pcq_q;
        if (pop)
            for (int i = 0; i < N - 1; i++) buf_d[i] = buf_q[i + 1];
        if (keep)
            for (int i = 0; i < N; i++)
                if (i == bidx) buf_d[i] = {b.inst_sram_rdata, pcq_q[0]};
        if (dok)
            for (int i = 0; i < N - 1; i++) pcq_d[i] = pcq_q[i + 1];
        if (acc)
            for (int i = 0; i < N; i++)
                if (i == pidx) pcq_d[i] = addr_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q        <= 1'b0;
            addr_q       <= '0;
            started_q    <= 1'b0;
            tgt_q        <= 1'b0;
            stale_q      <= 1'b0;
            br_pending_q <= 1'b0;
            br_target_q  <= '0;
            out_cnt_q    <= '0;
            buf_cnt_q    <= '0;
            discard_q    <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
                pcq_q[i] <= '0;
            end
        end else begin
            req_q        <= req_d;
            addr_q       <= addr_d;
            started_q    <= started_d;
            tgt_q        <= tgt_d;
            stale_q      <= stale_d;
            br_pending_q <= br_pending_d;
            br_target_q  <= br_target_d;
            out_cnt_q    <= out_cnt_d;
            buf_cnt_q    <= buf_cnt_d;
            discard_q    <= discard_d;
            buf_q        <= buf_d;
            pcq_q        <= pcq_d;
        end
    end

    assign b.inst_sram_req   = req_q;
    assign b.inst_sram_addr  = addr_q;
    assign b.inst_sram_wr    = 1'b0;
    assign b.inst_sram_size  = 2'b10;
    assign b.inst_sram_wstrb = 4'b0;
    assign b.inst_sram_wdata = 32'b0;
    assign b.fs_to_ds_valid  = (buf_cnt_q != '0);
    assign b.fs_to_ds_bus    = (buf_cnt_q != '0) ? buf_q[0] : 64'b0;

endmodule

// File: tb/tb_stage1_if.sv
// Bench for stage1_if: in-order SRAM model, scoreboard of expected {inst, pc}.
// Build with or without IF_PREFETCH_EN to match the RTL.
module tb_stage1_if;

`ifdef IF_PREFETCH_EN
    localparam int N = 2;
`else
    localparam int N = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [33:0] br_bus = '0;
    logic        hold_ds = 1'b0;
    logic        resp_hold = 1'b0;
    logic        stall_addr = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic [63:0] exp_q[$];
    logic [31:0] rq[$];
    logic [31:0] log_q[$];

    stage1_if_if bus ();

    stage1_if dut (
        .clk    (clk),
        .resetn (resetn),
        .br_bus (br_bus),
        .b      (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'ha5a5_0f0f;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (i < log_q.size()) ? log_q[i] : 32'hffff_ffff;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory side: addr_ok/data_ok change on the falling edge only.
    always @(negedge clk) begin
        bus.inst_sram_addr_ok = resetn && bus.inst_sram_req && !stall_addr;
        bus.inst_sram_data_ok = resetn && !resp_hold && rq.size() != 0;
        bus.inst_sram_rdata   = (rq.size() != 0) ? memf(rq[0]) : 32'h0;
    end

    always @(posedge clk) begin
        if (!resetn) begin
            rq.delete();
        end else begin
            if (bus.inst_sram_data_ok && rq.size() != 0) void'(rq.pop_front());
            if (bus.inst_sram_addr_ok) begin
                rq.push_back(bus.inst_sram_addr);
                log_q.push_back(bus.inst_sram_addr);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bus.ds_allow_in = !hold_ds && exp_q.size() != 0;
    end

    // Monitor: each accepted hand-off is compared against the scoreboard head.
    always @(negedge clk) begin
        if (resetn && bus.fs_to_ds_valid && bus.ds_allow_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=%h required=none",
                         bus.fs_to_ds_bus);
            end else begin
                chk("fs_to_ds_bus", bus.fs_to_ds_bus, exp_q.pop_front());
            end
        end
    end

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({memf(base + 32'(4 * i)), base + 32'(4 * i)});
    endtask

    task automatic wait_empty(input string name);
        int i;
        for (i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d left required=0", name,
                     exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_outstanding(input string name);
        int i;
        for (i = 0; i < 50 && rq.size() != N; i++) @(negedge clk);
        chk(name, 64'(rq.size()), 64'(N));
    endtask

    task automatic start_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        exp_q.delete();
        log_q.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic pulse_cancel(input logic [31:0] tgt);
        @(posedge clk);
        #1;
        br_bus = {2'b11, tgt};
        @(posedge clk);
        #1;
        br_bus = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset values and first request.
        start_reset();
        @(negedge clk);
        chk("rst_req", 64'(bus.inst_sram_req), 64'd0);
        chk("rst_addr", 64'(bus.inst_sram_addr), 64'd0);
        chk("rst_valid", 64'(bus.fs_to_ds_valid), 64'd0);
        chk("rst_bus", bus.fs_to_ds_bus, 64'd0);
        stall_addr = 1'b1;
        release_reset();
        @(posedge clk);
        #1;
        chk("first_req", 64'(bus.inst_sram_req), 64'd1);
        chk("first_addr", 64'(bus.inst_sram_addr), 64'h1c000000);
        stall_addr = 1'b0;

        // Sequential fetch, 1-cycle bus.
        start_reset();
        push_seq(32'h1c000000, 8);
        release_reset();
        wait_empty("seq");
        chk("seq_addr0", 64'(log_at(0)), 64'h1c000000);
        chk("seq_addr1", 64'(log_at(1)), 64'h1c000004);
        chk("seq_addr2", 64'(log_at(2)), 64'h1c000008);

        // Decode stall: fetch stops at N in flight, nothing lost on release.
        start_reset();
        hold_ds = 1'b1;
        release_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_issued", 64'(log_q.size()), 64'(N));
        chk("stall_req", 64'(bus.inst_sram_req), 64'd0);
        push_seq(32'h1c000000, 6);
        hold_ds = 1'b0;
        wait_empty("stall");

        // Redirect with N requests outstanding.
        start_reset();
        resp_hold = 1'b1;
        release_reset();
        wait_outstanding("cxl_outstanding");
        @(negedge clk);
        chk("cxl_req_idle", 64'(bus.inst_sram_req), 64'd0);
        pulse_cancel(32'h1c000100);
        push_seq(32'h1c000100, 3);
        resp_hold = 1'b0;
        wait_empty("cxl_out");

        // Redirect while a request is held without addr_ok.
        start_reset();
        stall_addr = 1'b1;
        release_reset();
        for (k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("held_req", 64'(bus.inst_sram_req), 64'd1);
            chk("held_addr", 64'(bus.inst_sram_addr), 64'h1c000000);
        end
        @(posedge clk);
        #1;
        br_bus = {2'b11, 32'h1c000100};
        @(posedge clk);
        #1;
        br_bus = '0;
        stall_addr = 1'b0;
        push_seq(32'h1c000100, 3);
        wait_empty("cxl_held");
        chk("held_log0", 64'(log_at(0)), 64'h1c000000);
        chk("held_log1", 64'(log_at(1)), 64'h1c000100);

        // Redirect together with data_ok (and a pop when N=2).
        start_reset();
        if (N == 2) push_seq(32'h1c000000, 1);
        release_reset();
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            #2;
            if (bus.inst_sram_data_ok &&
                (N == 1 || (bus.fs_to_ds_valid && bus.ds_allow_in)))
                break;
        end
        chk("coinc_found", 64'(k < 50), 64'd1);
        br_bus = {2'b11, 32'h1c000100};
        @(posedge clk);
        #1;
        br_bus = '0;
        chk("coinc_valid", 64'(bus.fs_to_ds_valid), 64'd0);
        chk("coinc_bus", bus.fs_to_ds_bus, 64'd0);
        push_seq(32'h1c000100, 3);
        wait_empty("coinc");

        // Reset in the middle of outstanding requests.
        start_reset();
        resp_hold = 1'b1;
        release_reset();
        wait_outstanding("mid_outstanding");
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_req", 64'(bus.inst_sram_req), 64'd0);
        chk("mid_addr", 64'(bus.inst_sram_addr), 64'd0);
        chk("mid_valid", 64'(bus.fs_to_ds_valid), 64'd0);
        chk("mid_bus", bus.fs_to_ds_bus, 64'd0);
        repeat (2) @(posedge clk);
        resp_hold = 1'b0;
        log_q.delete();
        exp_q.delete();
        push_seq(32'h1c000000, 3);
        release_reset();
        wait_empty("restart");
        chk("restart_addr", 64'(log_at(0)), 64'h1c000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage1_if.md
# stage1_IF

Instruction-fetch stage of the five-stage LoongArch pipeline. Issues fetch requests on the SRAM-like instruction bus, matches returned words to their PCs, buffers them, and hands `{inst, pc}` to the decode stage over the `fs_to_ds` valid/allow-in handshake. It consumes the decode stage's branch bus to redirect fetch and discards every in-flight or buffered wrong-path instruction.

## Interface
- Parameters: none (the PC reset vector is the fixed constant 32'h1c000000).
- `clk` in 1: single clock, all state on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ds_allow_in` in 1: decode can accept this cycle.
- `fs_to_ds_valid` out 1: `fs_to_ds_bus` holds a valid instruction.
- `fs_to_ds_bus` out 64: `[63:32]` inst, `[31:0]` pc.
- `br_bus` in 34: `[33]` br_taken_cancel (redirect strobe), `[32]` br_taken (ignored), `[31:0]` br_target.
- `inst_sram_req` out 1; `inst_sram_wr` out 1 (constant 0); `inst_sram_size` out 2 (constant 2'b10); `inst_sram_wstrb` out 4 (constant 0); `inst_sram_wdata` out 32 (constant 0).
- `inst_sram_addr` out 32: fetch address.
- `inst_sram_addr_ok` in 1: request accepted this cycle.
- `inst_sram_data_ok` in 1: read data valid this cycle, returned in request order.
- `inst_sram_rdata` in 32: instruction word.

## Operation
- N = outstanding limit (1 or 2, see Configuration). Inst buffer: FIFO of `{inst, pc}` with depth N. PC queue: FIFO of accepted-request PCs with depth N.
- `out_cnt` = requests accepted but not yet returned. `buf_cnt` = buffer occupancy.
- Issue: `inst_sram_req` asserts when `out_cnt + buf_cnt < N` or a request is already held. Once asserted, `req` and `addr` stay stable until `addr_ok`.
- Next address: `br_target_r` if `br_pending`, else the last issued address + 4. The first request after reset is 32'h1c000000.
- On `addr_ok`: push addr to the PC queue, `out_cnt++`, and clear `br_pending` if this request carried the target.
- On `data_ok`: pop the PC queue, `out_cnt--`. If `discard_cnt > 0`, drop the word and `discard_cnt--`; otherwise push `{rdata, pc}` into the buffer.
- Output: `fs_to_ds_valid` = buffer non-empty. The bus shows the buffer head. The head pops when `fs_to_ds_valid && ds_allow_in`.
- Redirect (`br_bus[33]` = 1, single-cycle pulse):
  - Flush the buffer, including any word arriving that cycle.
  - Set `br_pending` and latch `br_target_r`.
  - `discard_cnt` = requests still owed after this cycle, i.e. accepted requests including an `addr_ok` this cycle.
  - A request held without `addr_ok` is marked stale. When it is accepted it still completes its handshake, and its response is discarded (`discard_cnt++`).
- A redirect that arrives while `br_pending` is already set overwrites the target.
- Simultaneous pop and push on the buffer: both take effect, and occupancy is unchanged.

## Timing
- Reset values: `inst_sram_req` = 0, `inst_sram_addr` = 0, `fs_to_ds_valid` = 0, `fs_to_ds_bus` = 0; all counters, pending and stale flags = 0.
- The first `req` asserts in the first clock edge after `resetn` deasserts.
- `data_ok` arrives no earlier than the cycle after its `addr_ok`. `fs_to_ds_valid` rises one cycle after a kept `data_ok` (the buffer is registered).
- Redirect: the first target-path request is presented in the cycle after the cancel pulse, or after the stale request's `addr_ok`.
- Asserting `resetn` mid-transaction clears all state immediately. The bus model is reset together with the core, so no response survives reset.
- Buffer full and `ds_allow_in` = 0: no new request issues, so `data_ok` can never overflow the buffer.

## Configuration
- `IF_PREFETCH_EN` defined: N = 2. Two requests may be outstanding, the buffer and PC queue have 2 entries, and `discard_cnt` is 2 bits wide.
- `IF_PREFETCH_EN` undefined: N = 1. At most one request is outstanding, both queues collapse to a single register, and `discard_cnt` is 1 bit wide.
- Bus format and handshake are identical in both builds.

## Test plan
- Reset, then a 1-cycle bus with `ds_allow_in` held at 1 → addresses 1c000000, 1c000004, 1c000008 in order; bus pc values match and inst equals memory.
- `ds_allow_in` = 0 for 10 cycles → `req` stops once `out_cnt + buf_cnt` reaches N; no word is lost or duplicated after release.
- Cancel to 1c000100 with 1 (N=1) or 2 (N=2) requests outstanding → the next N `data_ok` words are dropped; the next valid bus pc is 1c000100.
- Cancel while `req` is held with `addr_ok` = 0 for 3 cycles → the held address completes, its data is dropped, then 1c000100 is fetched.
- Cancel in the same cycle as a `data_ok` and a `ds_allow_in` pop → the buffer is empty next cycle; no stale pc reaches `fs_to_ds_bus`.
- Drop `resetn` while 2 requests are outstanding (N=2) → all outputs are 0 immediately; fetch restarts at 1c000000.
